rv_fetch_queue: RTL and testbench

RV_FETCH_QUEUE -- requirements
Module: rv_fetch_queue

---
 rtl/rv_pkg.sv | 16 +
 rtl/rv_sync_fifo.sv | 70 +++++++
 rtl/rv_fetch_queue.sv | 118 +++++++++++
 tb/tb_rv_fetch_queue.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared constants for the RISC-V fetch path.
package rv_pkg;

    // Default address / PC width.
    localparam int unsigned XLEN_DEFAULT = 32;

    // Instruction width. Compressed instructions are not handled here.
    localparam int unsigned ILEN = 32;

    // Default first fetch address. Sized for the widest supported XLEN.
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

    // Canonical NOP encoding: addi x0, x0, 0.
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with flush and an occupancy count. The head entry is
// read straight from storage, so the head is always a registered value.
module rv_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    // Popping from empty is ignored: there is no push-to-pop bypass.
    assign do_pop    = pop && (count != '0);
    // A full FIFO still accepts a push if the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // Pointers and count. Flush empties the FIFO and wins over push/pop.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage.
    // NOTE: the storage array is reset on purpose so the head entry reads
    // as zero while reset is held; DEPTH is small so this is cheap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rv_fetch_queue.sv
// Instruction fetch queue: issues sequential fetch requests under a credit
// limit, tags returning instructions with their PC, and holds them for
// decode. A redirect flushes the queue and discards responses to requests
// issued before it.
module rv_fetch_queue
    import rv_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0]
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [XLEN-1:0]          imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [ILEN-1:0]          imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    input  logic                     pause,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ILEN-1:0]          out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = ILEN + XLEN;

    // Next address to request.
    logic [XLEN-1:0] fetch_pc;
    // PC belonging to the next response that will be kept.
    logic [XLEN-1:0] rsp_pc;
    // Accepted requests whose responses will be kept.
    logic [CW-1:0]   outstanding;
    // Accepted requests whose responses must be thrown away (pre-redirect).
    logic [CW-1:0]   drop_cnt;

    logic [CW+1:0]   credit_sum;
    logic            req_fire;
    logic            rsp_keep;
    logic            rsp_drop;
    logic            pop;
    logic [EW-1:0]   head_data;

    // Every accepted request reserves a queue slot until its response has
    // either landed or been dropped, so the queue can never overflow.
    assign credit_sum     = {2'b00, occupancy} + {2'b00, outstanding} + {2'b00, drop_cnt};
    assign imem_req_valid = reset && !pause && !redirect_valid
                            && (credit_sum < (CW + 2)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses come back in order, so pre-redirect responses are always
    // the first drop_cnt arrivals. A response in the redirect cycle itself
    // is discarded as well.
    assign rsp_keep  = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign rsp_drop  = imem_rsp_valid && (drop_cnt != '0);

    assign out_valid = (occupancy != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = head_data[ILEN-1:0];
    assign out_pc    = head_data[ILEN +: XLEN];

    // Fetch address: redirect target, else advance by one instruction on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    // Response PC: restarts at the redirect target, advances per kept response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            rsp_pc <= redirect_pc;
        end else if (rsp_keep) begin
            rsp_pc <= rsp_pc + XLEN'(4);
        end
    end

    // In-flight bookkeeping. On redirect every live request becomes stale;
    // a response arriving that cycle retires one of them immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            outstanding <= '0;
            drop_cnt    <= drop_cnt + outstanding - CW'(imem_rsp_valid);
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
            drop_cnt    <= drop_cnt - CW'(rsp_drop);
        end
    end

    rv_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_keep),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head_data),
        .count     (occupancy)
    );

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Bench for rv_fetch_queue: a behavioural instruction memory plus a
// program-order model of what decode must see and how many entries it holds.
module tb_rv_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam int          OW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk = 1'b0;
    logic              reset;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              pause;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [XLEN-1:0]   out_pc;
    logic [OW-1:0]     occupancy;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];

    int          vectors;
    int          miscompares;
    int          cyc;
    int          epoch;
    int          exp_occ;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    int          first_acc;
    int          first_val;
    int          lat;
    bit          lat_rand;
    bit          last_pop;

    rv_fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pause          (pause),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // Instruction content at an address: a scrambled copy of the address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h3C5A_0013;
    endfunction

    // Hold reset for two cycles, clear the model, release on a falling edge.
    task automatic do_reset();
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        pause          = 1'b0;
        out_ready      = 1'b1;
        mem_q.delete();
        acc_log.delete();
        pop_log.delete();
        exp_occ   = 0;
        exp_pc    = RESET_PC;
        exp_fetch = RESET_PC;
        epoch     = 0;
        first_acc = -1;
        first_val = -1;
        lat       = 1;
        lat_rand  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    // One clock cycle: memory answers, outputs are checked against the
    // model, then handshakes are recorded. Starts and ends on a falling edge.
    task automatic tick(input bit redir, input logic [31:0] rpc);
        bit keep;
        bit exp_ov;
        bit exp_rv;
        int inflight;
        keep           = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0].addr);
            keep           = (mem_q[0].epoch == epoch) && !redir;
            mem_q.delete(0);
        end
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        inflight = mem_q.size() + (imem_rsp_valid ? 1 : 0);
        exp_ov   = (exp_occ != 0);
        exp_rv   = !pause && !redir && ((exp_occ + inflight) < DEPTH);

        vectors++;
        if (occupancy !== OW'(exp_occ)) begin
            miscompares++;
            $display("FAIL occupancy cycle %0d: got %0d expected %0d", cyc, occupancy, exp_occ);
        end
        vectors++;
        if (out_valid !== exp_ov) begin
            miscompares++;
            $display("FAIL out_valid cycle %0d: got %b expected %b", cyc, out_valid, exp_ov);
        end
        vectors++;
        if (imem_req_valid !== exp_rv) begin
            miscompares++;
            $display("FAIL req_valid cycle %0d: got %b expected %b", cyc, imem_req_valid, exp_rv);
        end
        if (exp_rv) begin
            vectors++;
            if (imem_req_addr !== exp_fetch) begin
                miscompares++;
                $display("FAIL req_addr cycle %0d: got %h expected %h", cyc, imem_req_addr, exp_fetch);
            end
        end

        last_pop = (out_valid === 1'b1) && (out_ready === 1'b1);
        if (last_pop) begin
            pop_log.push_back(out_pc);
            vectors++;
            if (out_pc !== exp_pc) begin
                miscompares++;
                $display("FAIL out_pc cycle %0d: got %h expected %h", cyc, out_pc, exp_pc);
            end
            vectors++;
            if (out_instr !== instr_of(exp_pc)) begin
                miscompares++;
                $display("FAIL out_instr cycle %0d: got %h expected %h", cyc, out_instr, instr_of(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
        end
        if (out_valid === 1'b1 && first_val < 0) begin
            first_val = cyc;
        end

        if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
            mem_q.push_back('{addr: imem_req_addr,
                              due: cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat),
                              epoch: epoch});
            acc_log.push_back(imem_req_addr);
            if (first_acc < 0) begin
                first_acc = cyc;
            end
            exp_fetch = exp_fetch + 32'd4;
        end

        if (redir) begin
            exp_occ   = 0;
            exp_pc    = rpc;
            exp_fetch = rpc;
            epoch++;
        end else begin
            exp_occ = exp_occ + (keep ? 1 : 0) - ((exp_ov && out_ready) ? 1 : 0);
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Outputs while reset is held low.
    task automatic test_reset();
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        pause          = 1'b0;
        out_ready      = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (occupancy !== '0) begin miscompares++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        vectors++;
        if (out_pc !== '0) begin miscompares++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
        vectors++;
        if (out_instr !== '0) begin miscompares++; $display("FAIL reset_out_instr: got %h expected 0", out_instr); end
        vectors++;
        if (imem_req_addr !== RESET_PC) begin miscompares++; $display("FAIL reset_req_addr: got %h expected %h", imem_req_addr, RESET_PC); end
    endtask

    // Zero-wait memory, decode always ready: 0x0, 0x4, 0x8 with two-cycle latency.
    task automatic test_stream();
        do_reset();
        repeat (8) tick(1'b0, '0);
        vectors++;
        if (first_val - first_acc !== 2) begin
            miscompares++;
            $display("FAIL stream_latency: got %0d cycles expected 2", first_val - first_acc);
        end
        vectors++;
        if (pop_log.size() < 3) begin
            miscompares++;
            $display("FAIL stream_pops: got %0d expected at least 3", pop_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (pop_log[i] !== 32'(i * 4)) begin
                    miscompares++;
                    $display("FAIL stream_pc%0d: got %h expected %h", i, pop_log[i], 32'(i * 4));
                end
            end
        end
    endtask

    // Decode stalled: four requests fill the queue, then one pop frees a credit.
    task automatic test_full();
        do_reset();
        out_ready = 1'b0;
        repeat (10) tick(1'b0, '0);
        vectors++;
        if (acc_log.size() !== 4) begin
            miscompares++;
            $display("FAIL full_accepts: got %0d expected 4", acc_log.size());
        end else begin
            vectors++;
            if (acc_log[3] !== 32'hC) begin
                miscompares++;
                $display("FAIL full_last_addr: got %h expected 0000000c", acc_log[3]);
            end
        end
        vectors++;
        if (occupancy !== OW'(4)) begin miscompares++; $display("FAIL full_occupancy: got %0d expected 4", occupancy); end
        vectors++;
        if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_req_held: got %b expected 0", imem_req_valid); end
        out_ready = 1'b1;
        tick(1'b0, '0);
        out_ready = 1'b0;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL full_req_after_pop: got %b expected 1", imem_req_valid); end
        vectors++;
        if (occupancy !== OW'(3)) begin miscompares++; $display("FAIL full_occ_after_pop: got %0d expected 3", occupancy); end
    endtask

    // Latency 3, redirect with two requests in flight: both must be dropped.
    task automatic test_redirect();
        int n0;
        do_reset();
        lat = 3;
        repeat (2) tick(1'b0, '0);
        vectors++;
        if (acc_log.size() !== 2) begin miscompares++; $display("FAIL redir_inflight: got %0d expected 2", acc_log.size()); end
        tick(1'b1, 32'h100);
        n0 = pop_log.size();
        vectors++;
        if (n0 !== 0) begin miscompares++; $display("FAIL redir_early_pop: got %0d pops expected 0", n0); end
        repeat (10) tick(1'b0, '0);
        vectors++;
        if (pop_log.size() <= n0) begin
            miscompares++;
            $display("FAIL redir_no_output: got %0d pops expected more than %0d", pop_log.size(), n0);
        end else begin
            vectors++;
            if (pop_log[n0] !== 32'h100) begin miscompares++; $display("FAIL redir_first_pc: got %h expected 00000100", pop_log[n0]); end
        end
    endtask

    // Redirect in the same cycle as a response and a pop.
    task automatic test_redirect_rsp_pop();
        int n0;
        do_reset();
        lat = 2;
        repeat (6) tick(1'b0, '0);
        tick(1'b1, 32'h200);
        vectors++;
        if (last_pop !== 1'b1) begin miscompares++; $display("FAIL rrp_pop_in_redirect: got %b expected 1", last_pop); end
        vectors++;
        if (occupancy !== '0) begin miscompares++; $display("FAIL rrp_flush_occ: got %0d expected 0", occupancy); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rrp_flush_valid: got %b expected 0", out_valid); end
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL rrp_credit: got %b expected 1", imem_req_valid); end
        n0 = pop_log.size();
        repeat (8) tick(1'b0, '0);
        vectors++;
        if (pop_log.size() <= n0) begin
            miscompares++;
            $display("FAIL rrp_no_output: got %0d pops expected more than %0d", pop_log.size(), n0);
        end else begin
            vectors++;
            if (pop_log[n0] !== 32'h200) begin miscompares++; $display("FAIL rrp_first_pc: got %h expected 00000200", pop_log[n0]); end
        end
    endtask

    // Fetch address wraps from the top of the address space to zero.
    task automatic test_wrap();
        int n0;
        do_reset();
        repeat (3) tick(1'b0, '0);
        n0 = acc_log.size();
        tick(1'b1, 32'hFFFF_FFFC);
        repeat (6) tick(1'b0, '0);
        vectors++;
        if (acc_log.size() < n0 + 2) begin
            miscompares++;
            $display("FAIL wrap_accepts: got %0d expected at least %0d", acc_log.size(), n0 + 2);
        end else begin
            vectors++;
            if (acc_log[n0] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr0: got %h expected fffffffc", acc_log[n0]); end
            vectors++;
            if (acc_log[n0 + 1] !== 32'h0) begin miscompares++; $display("FAIL wrap_addr1: got %h expected 00000000", acc_log[n0 + 1]); end
        end
    endtask

    // Pause with two requests in flight: both delivered, fetch resumes at 0x8.
    task automatic test_pause();
        int n_acc;
        int n_pop;
        do_reset();
        lat = 3;
        repeat (2) tick(1'b0, '0);
        pause = 1'b1;
        n_acc = acc_log.size();
        n_pop = pop_log.size();
        repeat (5) tick(1'b0, '0);
        vectors++;
        if (acc_log.size() !== n_acc) begin miscompares++; $display("FAIL pause_accepts: got %0d expected %0d", acc_log.size(), n_acc); end
        vectors++;
        if (pop_log.size() - n_pop !== 2) begin miscompares++; $display("FAIL pause_drain: got %0d pops expected 2", pop_log.size() - n_pop); end
        pause = 1'b0;
        repeat (3) tick(1'b0, '0);
        vectors++;
        if (acc_log.size() <= n_acc) begin
            miscompares++;
            $display("FAIL pause_resume: got %0d accepts expected more than %0d", acc_log.size(), n_acc);
        end else begin
            vectors++;
            if (acc_log[n_acc] !== 32'h8) begin miscompares++; $display("FAIL pause_resume_addr: got %h expected 00000008", acc_log[n_acc]); end
        end
    endtask

    // Random backpressure, latency, pause and redirects against the model.
    task automatic test_random();
        bit          redir;
        bit          prev_redir;
        logic [31:0] rpc;
        do_reset();
        lat_rand   = 1'b1;
        prev_redir = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            pause          = ($urandom_range(0, 15) == 0);
            redir          = !prev_redir && ($urandom_range(0, 31) == 0);
            rpc            = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) begin
                rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            end
            tick(redir, redir ? rpc : 32'h0);
            prev_redir = redir;
        end
    endtask

    // Reset asserted between clock edges takes effect without a clock.
    task automatic test_async_reset();
        do_reset();
        lat       = 2;
        out_ready = 1'b0;
        repeat (6) tick(1'b0, '0);
        vectors++;
        if (occupancy === '0) begin miscompares++; $display("FAIL areset_fill: got occupancy 0 expected nonzero"); end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (occupancy !== '0) begin miscompares++; $display("FAIL areset_occupancy: got %0d expected 0", occupancy); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL areset_req_valid: got %b expected 0", imem_req_valid); end
        vectors++;
        if (out_pc !== '0 || out_instr !== '0) begin
            miscompares++;
            $display("FAIL areset_head: got pc %h instr %h expected 0 and 0", out_pc, out_instr);
        end
        do_reset();
        repeat (4) tick(1'b0, '0);
        vectors++;
        if (acc_log.size() == 0 || acc_log[0] !== RESET_PC) begin
            miscompares++;
            $display("FAIL areset_restart: got %0d accepts, first addr %h expected %h",
                     acc_log.size(), (acc_log.size() != 0) ? acc_log[0] : 32'hX, RESET_PC);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_rsp_pop();
        test_wrap();
        test_pause();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
